// File: rtl/regset_seq_ctrl.sv
// Five-cycle instruction sequencer for the 6-bit CPU: IDLE/DECODE/READ/EXEC/WB, one write per instruction.
// Accepts a new instruction only in IDLE (instr_ready); HALT parks it until reset, illegal indices set err.
module regset_seq_ctrl #(
  parameter int DW   = 6,
  parameter int AW   = 3,
  parameter int NREG = 5,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [11:0]   instr,
  output logic          instr_ready,
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  output logic [AW-1:0] rf_wr,
  output logic          rf_we,
  output logic [DW-1:0] rf_wrd,
  output logic          busy,
  output logic          carry,
  output logic          halted,
  output logic          err,
  output logic [CW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_READ, S_EXEC, S_WB, S_HALTED
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [AW:0] LIM = (AW+1)'(NREG);

  state_t        r_state;
  state_t        w_next;
  logic [11:0]   r_ir;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_result;
  logic          r_carry;
  logic          r_halted;
  logic          r_err;
  logic [CW-1:0] r_retired;
  logic [AW-1:0] r_rf_ra;
  logic [AW-1:0] r_rf_rb;
  logic [AW-1:0] r_rf_wr;
  logic [DW-1:0] r_rf_wrd;
  logic          r_rf_we;

  logic [2:0]    w_op;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic          w_rd_bad;
  logic          w_ra_bad;
  logic          w_rb_bad;
  logic          w_illegal;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_alu;
  logic          w_alu_c;

  assign w_op     = r_ir[11:9];
  assign w_rd     = r_ir[8:6];
  assign w_ra     = r_ir[5:3];
  assign w_rb     = r_ir[2:0];
  assign w_rd_bad = {1'b0, w_rd} >= LIM;
  assign w_ra_bad = {1'b0, w_ra} >= LIM;
  assign w_rb_bad = {1'b0, w_rb} >= LIM;

  // NOP and HALT name no registers, so they can never be illegal.
  always_comb begin
    w_illegal = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: w_illegal = w_rd_bad | w_ra_bad | w_rb_bad;
      OP_LDI:                        w_illegal = w_rd_bad;
      OP_MOV:                        w_illegal = w_rd_bad | w_ra_bad;
      default:                       w_illegal = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, r_opa} + {1'b0, r_opb};

  always_comb begin
    w_alu   = r_result;
    w_alu_c = r_carry;
    case (w_op)
      OP_ADD: begin
        w_alu   = w_sum[DW-1:0];
        w_alu_c = w_sum[DW];
      end
      OP_SUB: begin
        w_alu   = r_opa - r_opb;
        w_alu_c = r_opa < r_opb;
      end
      OP_AND:  w_alu = r_opa & r_opb;
      OP_OR:   w_alu = r_opa | r_opb;
      OP_LDI:  w_alu = r_ir[DW-1:0];
      OP_MOV:  w_alu = r_opa;
      default: w_alu = r_result;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (instr_valid) w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_HALT)  w_next = S_HALTED;
        else if (w_illegal)   w_next = S_IDLE;
        else                  w_next = S_READ;
      end
      S_READ:   w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
      r_retired <= '0;
      r_rf_ra   <= '0;
      r_rf_rb   <= '0;
      r_rf_wr   <= '0;
      r_rf_wrd  <= '0;
      r_rf_we   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rf_we <= 1'b0;
      case (r_state)
        S_IDLE: if (instr_valid) r_ir <= instr;
        S_DECODE: begin
          if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
          end else if (w_illegal) begin
            r_err <= 1'b1;
          end else begin
            r_rf_ra <= w_ra;
            r_rf_rb <= w_rb;
          end
        end
        S_READ: begin
          r_opa <= rf_a;
          r_opb <= rf_b;
        end
        // Write port is loaded here so rf_we is a clean register during WB.
        S_EXEC: begin
          r_result <= w_alu;
          r_carry  <= w_alu_c;
          if (w_op != OP_NOP) begin
            r_rf_we  <= 1'b1;
            r_rf_wr  <= w_rd;
            r_rf_wrd <= w_alu;
          end
        end
        S_WB:    r_retired <= r_retired + 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign carry       = r_carry;
  assign halted      = r_halted;
  assign err         = r_err;
  assign retired     = r_retired;
  assign rf_ra       = r_rf_ra;
  assign rf_rb       = r_rf_rb;
  assign rf_wr       = r_rf_wr;
  assign rf_we       = r_rf_we;
  assign rf_wrd      = r_rf_wrd;

endmodule

// File: tb/tb_regset_seq_ctrl.sv
// Bench for regset_seq_ctrl: register file model, timeline-based reference model, directed and random stimulus.
module tb_regset_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  rf_ra, rf_rb, rf_wr;
  logic [5:0]  rf_a, rf_b, rf_wrd;
  logic        rf_we, busy, carry, halted, err;
  logic [7:0]  retired;

  regset_seq_ctrl #(.DW(6), .AW(3), .NREG(5), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_a(rf_a), .rf_b(rf_b),
    .rf_wr(rf_wr), .rf_we(rf_we), .rf_wrd(rf_wrd), .busy(busy), .carry(carry),
    .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  // Register set driven by the DUT's ports; it is not cleared by the sequencer reset.
  logic [5:0] regs [0:7] = '{default: 6'd0};
  assign rf_a = regs[rf_ra];
  assign rf_b = regs[rf_rb];
  always @(posedge clk) if (rst_n && rf_we) regs[rf_wr] <= rf_wrd;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted instruction becomes a set of absolute cycle
  // numbers at which its visible effects appear.
  int cyc = 0;
  int t_acc, t_end, t_free, t_err, t_halt, t_rd, t_wb;
  bit halt_pend;
  int p_ra, p_rb, p_wr, p_wrd, p_c;
  bit p_we, p_cupd;
  int e_ra, e_rb, e_wr, e_wrd, e_carry, e_halt, e_err, e_ret, e_we;
  int m_regs [0:7] = '{default: 0};

  function automatic bit is_illegal(input int op, input int rd, input int ra, input int rb);
    case (op)
      1, 2, 3, 4: return (rd >= 5) || (ra >= 5) || (rb >= 5);
      5:          return rd >= 5;
      6:          return (rd >= 5) || (ra >= 5);
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    t_acc = -10; t_end = -10; t_free = 0; t_err = -10; t_halt = -10; t_rd = -10; t_wb = -10;
    halt_pend = 0;
    e_ra = 0; e_rb = 0; e_wr = 0; e_wrd = 0; e_carry = 0; e_halt = 0; e_err = 0; e_ret = 0; e_we = 0;
  endtask

  task automatic model_accept(input int n, input logic [11:0] ins);
    int op, rd, ra, rb, a, b;
    op = ins[11:9]; rd = ins[8:6]; ra = ins[5:3]; rb = ins[2:0];
    t_acc = n;
    if (op == 7) begin
      halt_pend = 1; t_halt = n + 2; t_end = n + 1; t_free = 32'h3fff_ffff;
    end else if (is_illegal(op, rd, ra, rb)) begin
      t_err = n + 2; t_end = n + 1; t_free = n + 2;
    end else begin
      a = m_regs[ra]; b = m_regs[rb];
      t_rd = n + 2; p_ra = ra; p_rb = rb;
      t_wb = n + 4; t_end = n + 4; t_free = n + 5;
      p_we = (op != 0); p_wr = rd; p_cupd = 0; p_c = 0; p_wrd = 0;
      case (op)
        1: begin p_wrd = (a + b) % 64; p_cupd = 1; p_c = ((a + b) >= 64); end
        2: begin p_wrd = (a - b + 64) % 64; p_cupd = 1; p_c = (a < b); end
        3: p_wrd = a & b;
        4: p_wrd = a | b;
        5: p_wrd = ins[5:0];
        6: p_wrd = a;
        default: p_wrd = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    int e_busy, e_ready;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cyc == t_err)  e_err = 1;
      if (cyc == t_halt) e_halt = 1;
      if (cyc == t_rd) begin e_ra = p_ra; e_rb = p_rb; end
      if (cyc == t_wb) begin
        e_we = p_we;
        if (p_we) begin e_wr = p_wr; e_wrd = p_wrd; m_regs[p_wr] = p_wrd; end
        if (p_cupd) e_carry = p_c;
      end
      if (cyc == t_wb + 1) begin e_we = 0; e_ret = (e_ret + 1) % 256; end
    end
    e_busy  = (cyc > t_acc) && (cyc <= t_end);
    e_ready = !halt_pend && (cyc >= t_free);
    chk("instr_ready", instr_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("carry", carry, e_carry);
    chk("halted", halted, e_halt);
    chk("err", err, e_err);
    chk("retired", retired, e_ret);
    chk("rf_we", rf_we, e_we);
    chk("rf_wr", rf_wr, e_wr);
    chk("rf_wrd", rf_wrd, e_wrd);
    chk("rf_ra", rf_ra, e_ra);
    chk("rf_rb", rf_rb, e_rb);
    if (rst_n && instr_valid && e_ready) model_accept(cyc, instr);
    cyc++;
  end

  function automatic logic [11:0] enc(input int op, input int rd, input int ra, input int rb);
    logic [2:0] o, d, a, b;
    o = 3'(op); d = 3'(rd); a = 3'(ra); b = 3'(rb);
    return {o, d, a, b};
  endfunction

  function automatic int rnd_reg();
    return ($urandom % 8 == 0) ? $urandom_range(7, 5) : $urandom_range(4, 0);
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  // Leaves the caller one step into the DECODE cycle of the accepted instruction.
  task automatic issue(input logic [11:0] ins);
    wait_idle("issue");
    instr_valid = 1'b1; instr = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    int r0, we_seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", instr_ready, 1);
    chk("reset_retired", retired, 0);
    chk("reset_we", rf_we, 0);
    rst_n = 1'b1;

    issue(enc(5, 0, 0, 7));
    issue(enc(5, 1, 0, 6));
    issue(enc(1, 2, 0, 1));
    wait_idle("add1");
    chk("add1_r2", regs[2], 13);
    chk("add1_model_r2", m_regs[2], 13);
    chk("add1_carry", carry, 0);
    chk("add1_retired", retired, 3);

    issue(enc(5, 0, 7, 7));
    issue(enc(5, 1, 0, 1));
    issue(enc(1, 3, 0, 1));
    wait_idle("add2");
    chk("add2_r3", regs[3], 0);
    chk("add2_carry", carry, 1);
    issue(enc(2, 4, 1, 0));
    wait_idle("sub");
    chk("sub_r4", regs[4], 2);
    chk("sub_model_r4", m_regs[4], 2);
    chk("sub_carry", carry, 1);

    r0 = retired;
    chk("illegal_err_before", err, 0);
    issue(enc(1, 5, 0, 1));
    @(posedge clk); #1;
    chk("illegal_err", err, 1);
    chk("illegal_idle", instr_ready, 1);
    chk("illegal_retired", retired, r0);

    wait_idle("nop");
    r0 = retired;
    instr = '0; instr_valid = 1'b1;
    repeat (1280) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("nop_wrap_retired", retired, r0);
    chk("nop_idle", instr_ready, 1);

    repeat (400) begin
      @(posedge clk); #1;
      instr_valid = ($urandom % 4) != 0;
      instr = enc($urandom_range(6, 0), rnd_reg(), rnd_reg(), rnd_reg());
    end
    instr_valid = 1'b0;

    issue(enc(5, 0, 1, 1));
    issue(enc(5, 0, 0, 5));
    repeat (3) @(posedge clk);
    #1;
    chk("wb_we_high", rf_we, 1);
    chk("wb_wrd", rf_wrd, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_wrd", rf_wrd, 0);
    chk("arst_retired", retired, 0);
    chk("arst_err", err, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst_r0_kept", regs[0], 9);

    issue(enc(7, 0, 0, 0));
    @(posedge clk); #1;
    chk("halt_halted", halted, 1);
    chk("halt_ready", instr_ready, 0);
    chk("halt_busy", busy, 0);
    we_seen = 0;
    repeat (20) begin
      instr_valid = $urandom % 2;
      instr = enc(5, $urandom_range(4, 0), $urandom_range(7, 0), $urandom_range(7, 0));
      @(posedge clk); #1;
      if (rf_we) we_seen++;
    end
    instr_valid = 1'b0;
    chk("halt_no_writes", we_seen, 0);
    chk("halt_sticky", halted, 1);

    @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
